// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low row drive, debounces a
// closed key over several scan ticks and pushes accepted codes into an 8-digit buffer.
module keypad_scanner #(
  parameter int SCAN_DIV  = 200000,
  parameter int DEB_SCANS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      COL,
  input  logic            clr,
  output logic [3:0]      ROW,
  output logic [3:0]      key_code,
  output logic            key_valid,
  output logic [7:0][3:0] num
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEB_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_SCANS);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        col_meta_q, col_sync_q;
  logic [DIV_W-1:0]  div_q;
  logic [3:0]        row_q, row_d;
  logic [1:0]        row_idx_q, row_idx_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [CNT_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0]  rel_cnt_q, rel_cnt_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic [7:0][3:0]   num_q, num_d;
  logic              tick_s;
  logic              accept_s;
  logic [3:0]        accept_key_s;

  // A corrupted row register falls back to row 0 so ROW stays one-hot.
  function automatic logic [3:0] row_rotate(input logic [3:0] row);
    case (row)
      4'b1110: row_rotate = 4'b1101;
      4'b1101: row_rotate = 4'b1011;
      4'b1011: row_rotate = 4'b0111;
      4'b0111: row_rotate = 4'b1110;
      default: row_rotate = 4'b1110;
    endcase
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] row);
    case (row)
      4'b1110: row_index = 2'd0;
      4'b1101: row_index = 2'd1;
      4'b1011: row_index = 2'd2;
      4'b0111: row_index = 2'd3;
      default: row_index = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] lowest_zero(input logic [3:0] col);
    casez (col)
      4'b???0: lowest_zero = 2'd0;
      4'b??01: lowest_zero = 2'd1;
      4'b?011: lowest_zero = 2'd2;
      default: lowest_zero = 2'd3;
    endcase
  endfunction

  function automatic logic [3:0] col_pattern(input logic [1:0] idx);
    col_pattern = ~(4'b0001 << idx);
  endfunction

  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_lookup = 4'h1;
      4'h1: key_lookup = 4'h2;
      4'h2: key_lookup = 4'h3;
      4'h3: key_lookup = 4'hA;
      4'h4: key_lookup = 4'h4;
      4'h5: key_lookup = 4'h5;
      4'h6: key_lookup = 4'h6;
      4'h7: key_lookup = 4'hB;
      4'h8: key_lookup = 4'h7;
      4'h9: key_lookup = 4'h8;
      4'hA: key_lookup = 4'h9;
      4'hB: key_lookup = 4'hC;
      4'hC: key_lookup = 4'hE;
      4'hD: key_lookup = 4'h0;
      4'hE: key_lookup = 4'hF;
      default: key_lookup = 4'hD;
    endcase
  endfunction

  assign tick_s = (div_q == DIV_LAST);

  // Column synchronizer and free-running scan divider.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
      div_q      <= {DIV_W{1'b0}};
    end else begin
      col_meta_q <= COL;
      col_sync_q <= col_meta_q;
      div_q      <= tick_s ? {DIV_W{1'b0}} : div_q + DIV_W'(1);
    end
  end

  // Scan/debounce/hold state and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SCAN;
      row_q       <= 4'b1110;
      row_idx_q   <= 2'd0;
      col_idx_q   <= 2'd0;
      deb_cnt_q   <= {CNT_W{1'b0}};
      rel_cnt_q   <= {CNT_W{1'b0}};
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      num_q       <= {8{4'h0}};
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      row_idx_q   <= row_idx_d;
      col_idx_q   <= col_idx_d;
      deb_cnt_q   <= deb_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      num_q       <= num_d;
    end
  end

  // Next-state logic; all decisions are taken on the scan tick only.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    row_idx_d    = row_idx_q;
    col_idx_d    = col_idx_q;
    deb_cnt_d    = deb_cnt_q;
    rel_cnt_d    = rel_cnt_q;
    key_code_d   = key_code_q;
    key_valid_d  = 1'b0;
    accept_s     = 1'b0;
    accept_key_s = key_code_q;
    num_d        = num_q;

    if (tick_s) begin
      case (state_q)
        SCAN: begin
          if (col_sync_q == 4'hF) begin
            row_d = row_rotate(row_q);
          end else begin
            row_idx_d = row_index(row_q);
            col_idx_d = lowest_zero(col_sync_q);
            deb_cnt_d = CNT_W'(1);
            // A single required scan accepts on the detecting tick itself.
            if (deb_cnt_d == DEB_LAST) begin
              accept_s     = 1'b1;
              accept_key_s = key_lookup(row_idx_d, col_idx_d);
            end else begin
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (col_sync_q == col_pattern(col_idx_q)) begin
            deb_cnt_d = deb_cnt_q + CNT_W'(1);
            if (deb_cnt_d == DEB_LAST) begin
              accept_s     = 1'b1;
              accept_key_s = key_lookup(row_idx_q, col_idx_q);
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            state_d = SCAN;
          end
        end
        HOLD: begin
          if (col_sync_q == 4'hF) begin
            rel_cnt_d = rel_cnt_q + CNT_W'(1);
            if (rel_cnt_d == DEB_LAST) begin
              state_d = SCAN;
            end else begin
              state_d = HOLD;
            end
          end else begin
            rel_cnt_d = {CNT_W{1'b0}};
          end
        end
        default: state_d = SCAN;
      endcase
    end else begin
      state_d = state_q;
    end

    if (accept_s) begin
      key_code_d  = accept_key_s;
      key_valid_d = 1'b1;
      state_d     = HOLD;
      rel_cnt_d   = {CNT_W{1'b0}};
    end else begin
      key_valid_d = 1'b0;
    end

    if (clr && accept_s) begin
      num_d = {{7{4'h0}}, accept_key_s};
    end else if (clr) begin
      num_d = {8{4'h0}};
    end else if (accept_s) begin
      num_d = {num_q[6:0], accept_key_s};
    end else begin
      num_d = num_q;
    end
  end

  assign ROW       = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign num       = num_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: a keypad matrix model drives COL from ROW; a transaction-level
// digit-buffer model predicts key codes, buffer contents and pulse counts.
module tb_keypad_scanner;

  localparam int SCAN_DIV  = 4;
  localparam int DEB_SCANS = 2;

  localparam logic [3:0] KMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                       4'h4, 4'h5, 4'h6, 4'hB,
                                       4'h7, 4'h8, 4'h9, 4'hC,
                                       4'hE, 4'h0, 4'hF, 4'hD};

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            clr = 1'b0;
  logic [3:0]      COL;
  logic [3:0]      ROW;
  logic [3:0]      key_code;
  logic            key_valid;
  logic [7:0][3:0] num;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         pulses   = 0;
  logic       kv_prev  = 1'b0;
  logic       kp_on    = 1'b0;
  logic       kp2_on   = 1'b0;
  int         kp_r = 0, kp_c = 0, kp2_r = 0, kp2_c = 0;
  logic [3:0] exp_num [8];

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEB_SCANS(DEB_SCANS)) dut (
    .clk(clk), .rst(rst), .COL(COL), .clr(clr),
    .ROW(ROW), .key_code(key_code), .key_valid(key_valid), .num(num)
  );

  always #5 clk = ~clk;

  // Physical keypad: a closed key pulls its column low while its row is driven.
  always_comb begin
    COL = 4'hF;
    if (kp_on && ROW[kp_r] == 1'b0) COL[kp_c] = 1'b0;
    if (kp2_on && ROW[kp2_r] == 1'b0) COL[kp2_c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Continuous properties: one-hot row drive and isolated key_valid pulses.
  always @(negedge clk) begin
    if (rst) begin
      check("row_onehot", $countones(~ROW), 1);
      if (key_valid) begin
        check("kv_consecutive", {31'd0, kv_prev}, 0);
        pulses++;
      end
      kv_prev = key_valid;
    end else begin
      kv_prev = 1'b0;
    end
  end

  function automatic logic [3:0] row_pat(input int r);
    logic [3:0] p;
    p = ~(4'b0001 << r);
    return p;
  endfunction

  function automatic logic [31:0] exp_packed();
    logic [31:0] p;
    for (int i = 0; i < 8; i++) p[i*4 +: 4] = exp_num[i];
    return p;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) exp_num[i] = 4'h0;
  endtask

  task automatic model_accept(input logic [3:0] k);
    for (int i = 7; i > 0; i--) exp_num[i] = exp_num[i-1];
    exp_num[0] = k;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * SCAN_DIV) @(negedge clk);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    check("clr_buffer", num, exp_packed());
  endtask

  // Waits until ROW has just switched to the given row.
  task automatic wait_row_fresh(input int r);
    logic [3:0] prev;
    bit         ok;
    ok   = 1'b0;
    prev = ROW;
    for (int i = 0; i < 10 * SCAN_DIV && !ok; i++) begin
      @(negedge clk);
      if (ROW == row_pat(r) && prev != row_pat(r)) ok = 1'b1;
      prev = ROW;
    end
    check("row_sync", {31'd0, ok}, 1);
  endtask

  // Press key index k until accepted, hold `extra` ticks (optionally pressing a
  // second key meanwhile), then release and let the release debounce finish.
  task automatic press_key(input int k, input int extra, input int second, input bit clr_acc);
    int r, c, p0;
    bit got;
    r   = k / 4;
    c   = k % 4;
    p0  = pulses;
    got = 1'b0;
    kp_r = r; kp_c = c; kp_on = 1'b1;
    clr = clr_acc;
    for (int i = 0; i < 12 * SCAN_DIV && !got; i++) begin
      @(negedge clk);
      if (key_valid) got = 1'b1;
    end
    clr = 1'b0;
    check("accept_seen", {31'd0, got}, 1);
    if (got) begin
      check("key_code", key_code, KMAP[k]);
      if (clr_acc) model_clear();
      model_accept(KMAP[k]);
      check("num_after_accept", num, exp_packed());
    end
    for (int t = 0; t < extra; t++) begin
      if (second >= 0 && t == 0) begin
        kp2_r = second / 4; kp2_c = second % 4; kp2_on = 1'b1;
      end
      if (t == 3) kp2_on = 1'b0;
      wait_ticks(1);
      check("row_held", ROW, row_pat(r));
    end
    kp2_on = 1'b0;
    kp_on  = 1'b0;
    wait_ticks(1);
    check("row_held_release", ROW, row_pat(r));
    wait_ticks(DEB_SCANS + 1);
    check("one_pulse", pulses - p0, 1);
    check("num_idle", num, exp_packed());
  endtask

  initial begin
    int rot, p0, k;
    model_clear();

    // Reset values and the first tick exactly SCAN_DIV cycles after release.
    #23;
    check("rst_row", ROW, 4'hE);
    check("rst_kv", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_num", num, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (SCAN_DIV - 1) @(negedge clk);
    check("first_tick_early", ROW, 4'hE);
    @(negedge clk);
    check("first_tick", ROW, 4'hD);

    // Idle rotation for 20 ticks.
    rot = 1;
    for (int i = 0; i < 20; i++) begin
      wait_ticks(1);
      rot = (rot + 1) % 4;
      check("idle_row", ROW, row_pat(rot));
    end
    check("idle_no_pulse", pulses, 0);

    // Key 8 (row 2, column 1), held 3 ticks beyond acceptance.
    press_key(9, 3, -1, 1'b0);
    check("key8_code", key_code, 4'h8);
    check("key8_num0", num[0], 4'h8);

    // Digits 1..9: the oldest digit falls off the end.
    foreach (KMAP[i]) begin
      if (i < 11 && (i % 4) != 3) press_key(i, 0, -1, 1'b0);
    end
    check("seq_1to9", num, 32'h23456789);

    // Random keys with occasional idle clears.
    for (int i = 0; i < 12; i++) begin
      k = $urandom_range(0, 15);
      press_key(k, $urandom_range(0, 5), -1, 1'b0);
      if ($urandom_range(0, 3) == 0) do_clr();
    end

    // Second key on another row during hold is ignored; long hold has no repeat.
    press_key(5, 6, 10, 1'b0);
    press_key($urandom_range(0, 15), 50, -1, 1'b0);

    // One-tick glitch: aborted debounce, row kept one tick, then rotation.
    wait_row_fresh(1);
    p0 = pulses;
    kp_r = 1; kp_c = 2; kp_on = 1'b1;
    repeat (SCAN_DIV) @(negedge clk);
    kp_on = 1'b0;
    repeat (SCAN_DIV) @(negedge clk);
    check("glitch_row_kept", ROW, row_pat(1));
    repeat (SCAN_DIV) @(negedge clk);
    check("glitch_rotate", ROW, row_pat(2));
    wait_ticks(6);
    check("glitch_no_pulse", pulses - p0, 0);

    // Clear a full buffer, then clear coinciding with acceptance.
    for (int i = 0; i < 8; i++) press_key($urandom_range(0, 15), 0, -1, 1'b0);
    do_clr();
    check("clr_full_zero", num, 0);
    press_key(5, 0, -1, 1'b1);
    check("clr_acc_key5", num, 32'h00000005);
    press_key(6, 0, -1, 1'b0);
    press_key(13, 0, -1, 1'b1);
    check("clr_acc_key0", num, 32'h00000000);

    // Reset while key A is being debounced.
    press_key(2, 0, -1, 1'b0);
    wait_row_fresh(0);
    p0 = pulses;
    kp_r = 0; kp_c = 3; kp_on = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_deb_row", ROW, 4'hE);
    check("rst_deb_kv", key_valid, 0);
    check("rst_deb_code", key_code, 0);
    check("rst_deb_num", num, 0);
    model_clear();
    kp_on = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wait_ticks(8);
    check("rst_deb_no_pulse", pulses - p0, 0);
    check("rst_deb_num_after", num, exp_packed());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 200000: clk cycles per scan tick, legal range >= 2.
REQ-002 Parameter DEB_SCANS, default 4: consecutive ticks required for press/release acceptance, legal range >= 1.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 COL  input  4  keypad column lines, pulled up; 0 = key closed on the driven row; asynchronous to clk.
REQ-006 clr  input  1  synchronous clear of the digit buffer, active-high.
REQ-007 ROW  output  4  keypad row drive, active-low one-hot.
REQ-008 key_code  output  4  code of the last accepted key.
REQ-009 key_valid  output  1  one-cycle pulse when a key is accepted.
REQ-010 num  output  [3:0] x 8  digit buffer, num[0] newest; same format as the display driver digit input.

Function
REQ-011 COL shall pass through a two-flop synchronizer; all decisions use the synchronized value (colS).
REQ-012 A free-running counter shall run 0..SCAN_DIV-1 and wrap; tick is high for the one cycle when the counter equals SCAN_DIV-1.
REQ-013 The FSM shall have three states: SCAN, DEBOUNCE and HOLD; the reset state is SCAN.
REQ-014 SCAN, tick, colS == 4'hF: ROW rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110.
REQ-015 SCAN, tick, colS != 4'hF: latch the row index and the lowest-index zero column of colS; ROW holds; deb_cnt = 1; go to DEBOUNCE.
REQ-016 DEBOUNCE, tick: if colS equals the latched single-column pattern, deb_cnt increments; otherwise go to SCAN with ROW unchanged, and rotation resumes on the next tick.
REQ-017 DEBOUNCE: when deb_cnt reaches DEB_SCANS, key_code is updated, key_valid pulses for exactly one cycle, the buffer shifts, and the FSM goes to HOLD with rel_cnt = 0. With DEB_SCANS = 1, acceptance occurs on the tick that detected the key.
REQ-018 Key map, row r / col c (row0 = ROW 1110, col0 = COL[0]):
- r0 = 1,2,3,A
- r1 = 4,5,6,B
- r2 = 7,8,9,C
- r3 = E,0,F,D
REQ-019 HOLD, tick: colS == 4'hF increments rel_cnt; any zero clears rel_cnt. At rel_cnt == DEB_SCANS, go to SCAN.
REQ-020 While held there shall be no auto-repeat, and a second key pressed during HOLD shall be ignored.
REQ-021 Buffer shift on accept: num[i] <= num[i-1] for i = 7..1; num[0] <= key; the old num[7] is discarded.
REQ-022 clr without accept: all num = 0. clr in the same cycle as an accept: num[0] = key and num[7:1] = 0.
REQ-023 key_valid shall never be high on two consecutive cycles; ROW shall always be exactly one-hot low.

Reset
REQ-024 rst low shall asynchronously set the following: ROW = 4'b1110, key_code = 0, key_valid = 0, all num = 0, state = SCAN, and all counters and synchronizer flops = 0 / 4'hF respectively.
REQ-025 After rst release, the first tick shall occur SCAN_DIV cycles later. A reset mid-DEBOUNCE or mid-HOLD shall produce no key_valid pulse.

Verification (SCAN_DIV = 4, DEB_SCANS = 2)
REQ-026 Idle, COL = F for 20 ticks: ROW cycles E, D, B, 7 every 4 clk; key_valid stays 0.
REQ-027 Hold COL = 4'b1101 while ROW = 1011, stable for 3 ticks: one key_valid pulse, key_code = 8, num[0] = 8; ROW stays 1011 until 2 released ticks have passed.
REQ-028 Enter 1,2,3,4,5,6,7,8,9 in sequence: num[0..7] = 9,8,7,6,5,4,3,2.
REQ-029 Glitch: COL low for 1 tick only -> no key_valid, and scanning resumes.
REQ-030 Key held for 50 ticks: exactly one pulse. Assert clr with the buffer full -> all num = 0. Assert clr in the accept cycle of key 0 -> num[0] = 0 and the rest = 0.
REQ-031 Assert rst low during DEBOUNCE of key A -> no pulse, ROW = 1110, num retains no entry.
